// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin PWM/static output driver fed by the SPI register file.
// Optional macro PWM_SHADOW_DUTY_EN: duty updates are deferred to the period boundary.
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty_q;
    logic          tick;
    logic          wrap;
    logic          pwm_level;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;
    logic [15:0]   next_out;

    assign tick = (pre_cnt == PRE_MAX);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= 8'h00;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'h00;
`ifdef PWM_SHADOW_DUTY_EN
        end else if (wrap) begin
            duty_q <= pwm_duty_cycle;
`else
        end else begin
            duty_q <= pwm_duty_cycle;
`endif
        end
    end

    // 0xFF is full-on rather than 255/256 so the top code really means 100%.
    assign pwm_level = (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt < duty_q);

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign next_out = en_out & (~en_pwm | {16{pwm_level}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            out          <= next_out;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - scoreboard bench for pwm_peripheral.
module tb_pwm_peripheral;

    localparam int P   = 13;
    localparam int PER = 256 * P;
`ifdef PWM_SHADOW_DUTY_EN
    localparam int SHADOW = 1;
`else
    localparam int SHADOW = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out;
    logic        period_start;

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    typedef struct {
        int          tag;
        logic [16:0] val;
        logic [16:0] mask;
    } vec_t;

    vec_t out_q[$];
    int   high_q[$];
    int   low_q[$];
    int   period_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle vectors, out[0] run lengths, period_start spacing.
    initial begin
        vec_t e;
        logic prev0, prev_rst, prev_ps;
        int   hi_run, lo_run, ps_ref;
        prev0 = 1'b0; prev_rst = 1'b0; prev_ps = 1'b0;
        hi_run = 0; lo_run = 0; ps_ref = 0;
        forever begin
            @(negedge clk);
            while (out_q.size() > 0 && out_q[0].tag <= cyc) begin
                e = out_q.pop_front();
                if (e.tag < cyc)
                    cmp("out_late", e.tag, cyc);
                else
                    cmp("out", int'({period_start, out} & e.mask), int'(e.val & e.mask));
            end
            if (out[0]) begin
                if (!prev0) begin
                    if (low_q.size() > 0) cmp("low_time", lo_run, low_q.pop_front());
                    hi_run = 1;
                end else begin
                    hi_run++;
                end
            end else begin
                if (prev0) begin
                    if (high_q.size() > 0) cmp("high_time", hi_run, high_q.pop_front());
                    lo_run = 1;
                end else begin
                    lo_run++;
                end
            end
            prev0 = out[0];
            if (rst_n && !prev_rst) ps_ref = cyc;
            if (period_start) begin
                cmp("ps_width", int'(prev_ps), 0);
                if (period_q.size() > 0) cmp("period", cyc - ps_ref, period_q.pop_front());
                ps_ref = cyc;
            end
            prev_rst = rst_n;
            prev_ps  = period_start;
        end
    end

    task automatic expect_out(input int tag, input logic [15:0] v, input logic [15:0] m,
                              input logic chk_ps, input logic ps);
        vec_t e;
        e.tag  = tag;
        e.val  = {ps, v};
        e.mask = {chk_ps, m};
        out_q.push_back(e);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < budget);
        if (!period_start) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_ps: no period_start within %0d cycles, expected one", budget);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((out_q.size() + high_q.size() + low_q.size() + period_q.size()) != 0 && k < 3 * PER) begin
            @(negedge clk);
            k++;
        end
        cmp("drain", out_q.size() + high_q.size() + low_q.size() + period_q.size(), 0);
        out_q.delete(); high_q.delete(); low_q.delete(); period_q.delete();
    endtask

    initial begin
        // Reset held with every register at 0xFF.
        rst_n = 1'b0;
        {eo_lo, eo_hi, ep_lo, ep_hi, duty} = {5{8'hFF}};
        for (int i = 1; i <= 10; i++) expect_out(i, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        tick_n(10);
        {eo_lo, eo_hi, ep_lo, ep_hi, duty} = {5{8'h00}};
        rst_n = 1'b1;
        period_q.push_back(PER);

        // Static drive and one-clk latency.
        tick_n(3);
        eo_lo = 8'hFF; eo_hi = 8'hFF;
        expect_out(cyc,     16'h0000, 16'hFFFF, 1'b1, 1'b0);
        expect_out(cyc + 1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        tick_n(2);
        eo_hi = 8'h00;
        expect_out(cyc,     16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        expect_out(cyc + 1, 16'h00FF, 16'hFFFF, 1'b1, 1'b0);
        drain();

        // 50% duty on pin 0.
        eo_lo = 8'h01; eo_hi = 8'h00; ep_lo = 8'h01; ep_hi = 8'h00; duty = 8'h80;
        wait_ps(2 * PER);
        wait_ps(2 * PER);
        repeat (2) begin
            high_q.push_back(1664);
            low_q.push_back(1664);
            period_q.push_back(3328);
        end
        for (int i = 1; i <= 8; i++) expect_out(cyc + i, 16'h0000, 16'hFFFE, 1'b0, 1'b0);
        drain();

        // Extremes: 0x00 never high, 0xFF never low.
        duty = 8'h00;
        wait_ps(2 * PER);
        for (int i = 1; i <= 2 * PER; i++) expect_out(cyc + i, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        period_q.push_back(PER); period_q.push_back(PER);
        drain();
        duty = 8'hFF;
        wait_ps(2 * PER);
        for (int i = 1; i <= 2 * PER; i++) expect_out(cyc + i, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
        period_q.push_back(PER); period_q.push_back(PER);
        drain();

        // Duty 0x40 -> 0xC0 written at pwm_cnt 0x20.
        duty = 8'h40;
        wait_ps(2 * PER);
        wait_ps(2 * PER);
        high_q.push_back(SHADOW ? 832 : 2496);
        high_q.push_back(2496);
        period_q.push_back(PER); period_q.push_back(PER);
        tick_n(32 * P);
        duty = 8'hC0;
        drain();

        // Asynchronous reset at pwm_cnt 0x90.
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'h01; ep_hi = 8'h00; duty = 8'hC0;
        wait_ps(2 * PER);
        tick_n(144 * P - 1);
        expect_out(cyc, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        tick_n(1);
        rst_n = 1'b0;
        expect_out(cyc, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        tick_n(3);
        rst_n = 1'b1;
        period_q.push_back(PER);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
